// File: rtl/next_hop_select_pkg.sv
// Shared Q-table definitions: word width, neighbor table capacity and the
// next-hop scan FSM state encoding. Also used by the Q-table update logic.
package next_hop_select_pkg;

    localparam int QT_WORD_WIDTH    = 16;
    localparam int QT_MAX_NEIGHBORS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } nhs_state_e;

endpackage

// File: rtl/next_hop_select_hop_compare.sv
// Combinational candidate-vs-best decision for the next-hop scan.
// A candidate is eligible when its energy meets the floor; it replaces the
// current best when nothing has been found yet, when its Q value is higher,
// or when Q ties and it has strictly more energy (a full tie keeps the
// earlier, lower-index entry).
module hop_compare #(
    parameter int WORD_WIDTH = 16
) (
    input  logic [WORD_WIDTH-1:0] cand_q_i,
    input  logic [WORD_WIDTH-1:0] cand_e_i,
    input  logic [WORD_WIDTH-1:0] min_e_i,
    input  logic [WORD_WIDTH-1:0] best_q_i,
    input  logic [WORD_WIDTH-1:0] best_e_i,
    input  logic                  found_i,
    output logic                  replace_o
);

    logic eligible;
    logic better;

    assign eligible  = (cand_e_i >= min_e_i);
    assign better    = (cand_q_i > best_q_i) ||
                       ((cand_q_i == best_q_i) && (cand_e_i > best_e_i));
    assign replace_o = eligible && (!found_i || better);

endmodule

// File: rtl/next_hop_select.sv
// Next-hop selector: scans the neighbor banks from index 0 to N-1 and keeps
// the eligible entry with the best Q value (energy breaks Q ties). Bank reads
// are synchronous, so a two-stage valid/last pipeline follows each address
// until its data is evaluated.
module next_hop_select
    import next_hop_select_pkg::*;
#(
    parameter int WORD_WIDTH    = QT_WORD_WIDTH,
    parameter int MAX_NEIGHBORS = QT_MAX_NEIGHBORS
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] neighborCount,
    input  logic [WORD_WIDTH-1:0] minEnergy,
    output logic [WORD_WIDTH-1:0] rd_index,
    input  logic [WORD_WIDTH-1:0] mSourceID,
    input  logic [WORD_WIDTH-1:0] mClusterID,
    input  logic [WORD_WIDTH-1:0] mEnergyLeft,
    input  logic [WORD_WIDTH-1:0] mQValue,
    output logic [WORD_WIDTH-1:0] bestID,
    output logic [WORD_WIDTH-1:0] bestClusterID,
    output logic [WORD_WIDTH-1:0] bestEnergy,
    output logic [WORD_WIDTH-1:0] bestQValue,
    output logic                  found,
    output logic                  busy,
    output logic                  done
);

    localparam logic [WORD_WIDTH-1:0] MAXN = WORD_WIDTH'(MAX_NEIGHBORS);
    localparam logic [WORD_WIDTH-1:0] ONE  = WORD_WIDTH'(1);

    nhs_state_e            state_q;
    logic [WORD_WIDTH-1:0] n_q, min_q, rd_q;
    logic [WORD_WIDTH-1:0] bid_q, bcl_q, be_q, bqv_q;
    logic                  found_q, done_q;
    // [0]: address on rd_index is live; [1]: bank data for it is live
    logic [1:0]            vld_q, last_q;

    logic [WORD_WIDTH-1:0] n_cap, last_idx;
    logic                  replace;

    assign n_cap    = (neighborCount > MAXN) ? MAXN : neighborCount;
    assign last_idx = n_q - ONE;

    hop_compare #(.WORD_WIDTH(WORD_WIDTH)) u_cmp (
        .cand_q_i  (mQValue),
        .cand_e_i  (mEnergyLeft),
        .min_e_i   (min_q),
        .best_q_i  (bqv_q),
        .best_e_i  (be_q),
        .found_i   (found_q),
        .replace_o (replace)
    );

    // Scan FSM, address generator, read-valid pipeline and best-entry registers
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            min_q   <= '0;
            rd_q    <= '0;
            bid_q   <= '0;
            bcl_q   <= '0;
            be_q    <= '0;
            bqv_q   <= '0;
            found_q <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            last_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            vld_q     <= {vld_q[0], 1'b0};
            last_q    <= {last_q[0], 1'b0};

            if (vld_q[1] && replace) begin
                bid_q   <= mSourceID;
                bcl_q   <= mClusterID;
                be_q    <= mEnergyLeft;
                bqv_q   <= mQValue;
                found_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        n_q     <= n_cap;
                        min_q   <= minEnergy;
                        rd_q    <= '0;
                        bid_q   <= '0;
                        bcl_q   <= '0;
                        be_q    <= '0;
                        bqv_q   <= '0;
                        found_q <= 1'b0;
                        if (n_cap == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q   <= ST_SCAN;
                            vld_q[0]  <= 1'b1;
                            last_q[0] <= (n_cap == ONE);
                        end
                    end
                end
                ST_SCAN: begin
                    if (rd_q == last_idx) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        rd_q      <= rd_q + ONE;
                        vld_q[0]  <= 1'b1;
                        last_q[0] <= ((rd_q + ONE) == last_idx);
                    end
                end
                ST_DRAIN: begin
                    if (vld_q[1] && last_q[1]) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_index      = rd_q;
    assign bestID        = bid_q;
    assign bestClusterID = bcl_q;
    assign bestEnergy    = be_q;
    assign bestQValue    = bqv_q;
    assign found         = found_q;
    assign done          = done_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_next_hop_select.sv
// Directed bench for next_hop_select with a synchronous-read bank model.
module tb_next_hop_select;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         nrst, en;
    logic [W-1:0] neighborCount, minEnergy, rd_index;
    logic [W-1:0] mSourceID, mClusterID, mEnergyLeft, mQValue;
    logic [W-1:0] bestID, bestClusterID, bestEnergy, bestQValue;
    logic         found, busy, done;

    logic [W-1:0] id_mem [64];
    logic [W-1:0] cl_mem [64];
    logic [W-1:0] e_mem  [64];
    logic [W-1:0] q_mem  [64];

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    // Banks: data for an address is valid one edge after it is presented
    always @(posedge clk) begin
        mSourceID   <= id_mem[rd_index[5:0]];
        mClusterID  <= cl_mem[rd_index[5:0]];
        mEnergyLeft <= e_mem[rd_index[5:0]];
        mQValue     <= q_mem[rd_index[5:0]];
    end

    next_hop_select dut (
        .clk(clk), .nrst(nrst), .en(en),
        .neighborCount(neighborCount), .minEnergy(minEnergy),
        .rd_index(rd_index),
        .mSourceID(mSourceID), .mClusterID(mClusterID),
        .mEnergyLeft(mEnergyLeft), .mQValue(mQValue),
        .bestID(bestID), .bestClusterID(bestClusterID),
        .bestEnergy(bestEnergy), .bestQValue(bestQValue),
        .found(found), .busy(busy), .done(done)
    );

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            id_mem[i] = '0; cl_mem[i] = '0; e_mem[i] = '0; q_mem[i] = '0;
        end
    endtask

    task automatic set_entry(input int idx, input logic [W-1:0] id, q, e);
        id_mem[idx] = id;
        cl_mem[idx] = id + 16'h0100;
        q_mem[idx]  = q;
        e_mem[idx]  = e;
    endtask

    task automatic load_basic();
        clear_mem();
        set_entry(0, 16'd1, 16'h3000, 16'h8000);
        set_entry(1, 16'd2, 16'hB800, 16'h1800);
        set_entry(2, 16'd3, 16'h2000, 16'h9000);
    endtask

    // Pulse en for one edge (E0), then watch 41 post-edge samples (k=0 is
    // right after E0). Records first done sample index, done count, max
    // rd_index and whether busy was ever seen.
    task automatic run_scan(input logic [W-1:0] cnt, input logic [W-1:0] min_e,
                            input bit repulse, output int done_edge,
                            output int done_cnt, output int max_rd,
                            output bit busy_seen);
        done_edge = -1; done_cnt = 0; max_rd = 0; busy_seen = 1'b0;
        @(negedge clk);
        neighborCount = cnt; minEnergy = min_e; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (repulse && k == 2) begin
                en = 1'b1; neighborCount = 16'd1; minEnergy = 16'hFFFF;
            end
            if (repulse && k == 3) en = 1'b0;
            if (done === 1'b1) begin
                if (done_edge < 0) done_edge = k;
                done_cnt++;
            end
            if (busy === 1'b1) busy_seen = 1'b1;
            if (int'(rd_index) > max_rd) max_rd = int'(rd_index);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b1; en = 1'b0; neighborCount = '0; minEnergy = '0;
        repeat (2) @(posedge clk);
        #1;
        tot_cnt++;
        if ({bestID, bestClusterID, bestEnergy, bestQValue} !== 64'h0)
            $display("FAIL reset_best: got %h want 0", {bestID, bestClusterID, bestEnergy, bestQValue});
        else pass_cnt++;
        tot_cnt++;
        if (rd_index !== 16'h0) $display("FAIL reset_rd: got %h want 0", rd_index); else pass_cnt++;
        tot_cnt++;
        if ({found, busy, done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {found, busy, done}); else pass_cnt++;
        @(negedge clk);
        nrst = 1'b0;
    endtask

    task automatic test_basic();
        int de, dc, mr; bit bs;
        load_basic();
        run_scan(16'd3, 16'h0000, 1'b0, de, dc, mr, bs);
        tot_cnt++;
        if (de !== 4 || dc !== 1) $display("FAIL basic_done: got edge %0d cnt %0d want edge 4 cnt 1", de, dc); else pass_cnt++;
        tot_cnt++;
        if ({bestID, bestClusterID, bestQValue, bestEnergy} !== {16'd2, 16'h0102, 16'hB800, 16'h1800})
            $display("FAIL basic_best: got %h %h %h %h want 0002 0102 b800 1800", bestID, bestClusterID, bestQValue, bestEnergy);
        else pass_cnt++;
        tot_cnt++;
        if (found !== 1'b1 || busy !== 1'b0) $display("FAIL basic_flags: got found %b busy %b want 1 0", found, busy); else pass_cnt++;
        tot_cnt++;
        if (mr !== 2) $display("FAIL basic_rdmax: got %0d want 2", mr); else pass_cnt++;
    endtask

    task automatic test_min_energy();
        int de, dc, mr; bit bs;
        load_basic();
        run_scan(16'd3, 16'h2000, 1'b0, de, dc, mr, bs);
        tot_cnt++;
        if ({bestID, bestQValue, bestEnergy, found} !== {16'd1, 16'h3000, 16'h8000, 1'b1})
            $display("FAIL minE_best: got id %h q %h e %h f %b want 0001 3000 8000 1", bestID, bestQValue, bestEnergy, found);
        else pass_cnt++;
    endtask

    task automatic test_tie();
        int de, dc, mr; bit bs;
        clear_mem();
        set_entry(0, 16'd5, 16'h4000, 16'h1000);
        set_entry(1, 16'd6, 16'h4000, 16'h2000);
        set_entry(2, 16'd7, 16'h4000, 16'h2000);
        run_scan(16'd3, 16'h0000, 1'b0, de, dc, mr, bs);
        tot_cnt++;
        if ({bestID, bestClusterID, bestEnergy} !== {16'd6, 16'h0106, 16'h2000})
            $display("FAIL tie_best: got id %h cl %h e %h want 0006 0106 2000", bestID, bestClusterID, bestEnergy);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        int de, dc, mr; bit bs;
        run_scan(16'd0, 16'h0000, 1'b0, de, dc, mr, bs);
        tot_cnt++;
        if (de !== 0 || dc !== 1) $display("FAIL zero_done: got edge %0d cnt %0d want edge 0 cnt 1", de, dc); else pass_cnt++;
        tot_cnt++;
        if (bs !== 1'b0) $display("FAIL zero_busy: got %b want 0", bs); else pass_cnt++;
        tot_cnt++;
        if (found !== 1'b0 || bestID !== 16'd0) $display("FAIL zero_found: got found %b id %h want 0 0000", found, bestID); else pass_cnt++;
    endtask

    task automatic test_cap();
        int de, dc, mr; bit bs;
        clear_mem();
        for (int i = 0; i < 32; i++) set_entry(i, 16'(i + 1), 16'(i), 16'h0100);
        set_entry(20, 16'd21, 16'h7000, 16'h0010);
        for (int i = 32; i < 40; i++) set_entry(i, 16'(i + 1), 16'hFFFF, 16'hFFFF);
        run_scan(16'd40, 16'h0000, 1'b0, de, dc, mr, bs);
        tot_cnt++;
        if (mr !== 31) $display("FAIL cap_rdmax: got %0d want 31", mr); else pass_cnt++;
        tot_cnt++;
        if (de !== 33 || dc !== 1) $display("FAIL cap_done: got edge %0d cnt %0d want edge 33 cnt 1", de, dc); else pass_cnt++;
        tot_cnt++;
        if (bestID !== 16'd21 || bestQValue !== 16'h7000) $display("FAIL cap_best: got id %h q %h want 0015 7000", bestID, bestQValue); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int de, dc, mr; bit bs;
        int waited, dones;
        load_basic();
        @(negedge clk);
        neighborCount = 16'd3; minEnergy = '0; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        waited = 0;
        while (rd_index !== 16'd1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        tot_cnt++;
        if (rd_index !== 16'd1) $display("FAIL mrst_wait: got rd %h want 0001 within 10 cycles", rd_index); else pass_cnt++;
        nrst = 1'b1;
        @(posedge clk); #1;
        tot_cnt++;
        if ({rd_index, bestID, bestClusterID, bestEnergy, bestQValue, found, busy, done} !== 83'h0)
            $display("FAIL mrst_clear: got rd %h id %h f %b b %b d %b want all 0", rd_index, bestID, found, busy, done);
        else pass_cnt++;
        @(negedge clk);
        nrst = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        tot_cnt++;
        if (dones !== 0) $display("FAIL mrst_nodone: got %0d done pulses want 0", dones); else pass_cnt++;
        run_scan(16'd3, 16'h0000, 1'b0, de, dc, mr, bs);
        tot_cnt++;
        if (de !== 4 || dc !== 1 || bestID !== 16'd2 || found !== 1'b1)
            $display("FAIL mrst_restart: got edge %0d cnt %0d id %h f %b want 4 1 0002 1", de, dc, bestID, found);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int de, dc, mr; bit bs;
        load_basic();
        run_scan(16'd3, 16'h0000, 1'b1, de, dc, mr, bs);
        tot_cnt++;
        if (de !== 4 || dc !== 1) $display("FAIL repulse_done: got edge %0d cnt %0d want edge 4 cnt 1", de, dc); else pass_cnt++;
        tot_cnt++;
        if (bestID !== 16'd2 || bestQValue !== 16'hB800 || mr !== 2)
            $display("FAIL repulse_best: got id %h q %h rdmax %0d want 0002 b800 2", bestID, bestQValue, mr);
        else pass_cnt++;
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_basic();
        test_min_energy();
        test_tie();
        test_zero();
        test_cap();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
